// File: rtl/npu_buf_arbiter_if.sv
// Requester/SRAM bus bundle for the activation buffer arbiter.
// master = requesters plus SRAM model side; slave = arbiter side.
interface npu_buf_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LEN_W   = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      busy;
  logic [2:0]                owner;

  modport master (
    output req, req_we, req_addr, req_wdata, req_len, mem_rdata,
    input  req_ready, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_len, mem_rdata,
    output req_ready, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/npu_buf_arbiter.sv
// Round-robin, burst-locked arbiter sharing the single-port activation buffer
// between the NPU controller, DMA and pooling unit, with tagged read return.
module npu_buf_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  npu_buf_arbiter_if.slave  bus
);

  localparam int unsigned OWN_W = 3;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_q, rr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [OWN_W-1:0]     winner, pos;
  logic [OWN_W:0]       win_sum;
  logic                 found;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0]   own_oh;
  logic                 accept;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [LEN_W-1:0]     win_len;
  logic [RD_LAT-1:0]    tag_v_q;
  logic [OWN_W-1:0]     tag_id_q [RD_LAT];

  // Circular first-set search starting at rr_q
  always_comb begin
    req_rot = {bus.req, bus.req} >> rr_q;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = OWN_W'(k);
      end
    end
    win_sum = {1'b0, rr_q} + {1'b0, pos};
    winner  = (win_sum >= (OWN_W+1)'(NUM_REQ)) ? OWN_W'(win_sum - (OWN_W+1)'(NUM_REQ))
                                                : OWN_W'(win_sum);
  end

  // Owner beat selection and winner length lookup
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    win_len   = '0;
    own_oh    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWN_W'(i)) begin
        own_oh[i] = 1'b1;
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
      if (winner == OWN_W'(i)) begin
        win_len = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign accept = (state_q == BURST) && !flush && |(bus.req & own_oh);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            owner_d = winner;
            cnt_d   = win_len;
            state_d = BURST;
          end
        end
        BURST: begin
          bus.req_ready = own_oh;
          if (accept) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = sel_we;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_wdata;
            if (cnt_q == '0) begin
              state_d = IDLE;
              rr_d    = (owner_q == OWN_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read tag pipeline: RD_LAT stages of {valid, owner}, wiped on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_id_q[i] <= '0;
    end else if (flush) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q[0]  <= accept && !sel_we;
      tag_id_q[0] <= owner_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    if (tag_v_q[RD_LAT-1]) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        bus.rvalid[i] = (tag_id_q[RD_LAT-1] == OWN_W'(i));
      end
      bus.rdata = bus.mem_rdata;
    end
  end

  assign bus.busy  = (state_q == BURST);
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_npu_buf_arbiter.sv
// Randomized bench for npu_buf_arbiter against a burst-level reference model
// with a behavioural SRAM attached to the memory port.
module tb_npu_buf_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned RD_LAT  = 2;
  localparam int          N_CYC   = 4000;

  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  npu_buf_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  npu_buf_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: burst level, counted in remaining beats
  bit                m_busy;
  int                m_owner, m_rr, m_left;
  rd_t               pend[$];
  logic [DATA_W-1:0] model_mem [int];

  // Behavioural SRAM driven by the DUT memory port
  logic [DATA_W-1:0] sram_mem [int];
  logic [DATA_W-1:0] sram_pipe [RD_LAT];
  logic              s_en, s_we;
  int                s_addr;
  logic [DATA_W-1:0] s_wd;

  function automatic logic [DATA_W-1:0] default_word(input int a);
    return {4{32'(a) ^ 32'hC0DE_0000}};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  DATA_W'(bus.req_ready), '0);
    check({tag, "_rvalid"}, DATA_W'(bus.rvalid),    '0);
    check({tag, "_rdata"},  bus.rdata,              '0);
    check({tag, "_mem_en"}, DATA_W'(bus.mem_en),    '0);
    check({tag, "_mem_we"}, DATA_W'(bus.mem_we),    '0);
    check({tag, "_addr"},   DATA_W'(bus.mem_addr),  '0);
    check({tag, "_wdata"},  bus.mem_wdata,          '0);
    check({tag, "_busy"},   DATA_W'(bus.busy),      '0);
    check({tag, "_owner"},  DATA_W'(bus.owner),     '0);
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    m_left  = 0;
    pend.delete();
  endtask

  task automatic drive_random(input int prob, input int flush_pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]    = ($urandom_range(0, 99) < prob);
      bus.req_we[i] = $urandom_range(0, 1) == 1;
      bus.req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom_range(0, 15));
      bus.req_wdata[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
      bus.req_len[i*LEN_W +: LEN_W] = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                                                   : LEN_W'($urandom_range(0, 3));
    end
    flush = ($urandom_range(0, 99) < flush_pct);
  endtask

  task automatic sram_clock();
    logic [DATA_W-1:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom};
    if (s_en && !s_we) rd = sram_mem.exists(s_addr) ? sram_mem[s_addr] : default_word(s_addr);
    if (s_en && s_we) sram_mem[s_addr] = s_wd;
    for (int i = RD_LAT - 1; i > 0; i--) sram_pipe[i] = sram_pipe[i-1];
    sram_pipe[0]  = rd;
    bus.mem_rdata = sram_pipe[RD_LAT-1];
  endtask

  initial begin
    bit                 rst_pending;
    bit                 rst_done;
    int                 prob, fpct;
    bit                 acc, we;
    int                 addr, winner;
    logic [DATA_W-1:0]  wd, exp_rd;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;

    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_len = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < RD_LAT; i++) sram_pipe[i] = '0;
    s_en = 1'b0; s_we = 1'b0; s_addr = 0; s_wd = '0;
    model_reset();
    rst_pending = 1'b0;
    rst_done    = 1'b0;

    // Reset state with requests already asserted
    @(negedge clk);
    bus.req = '1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por_hold");
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (rst_pending) begin
        rst_n       = 1'b1;
        rst_pending = 1'b0;
      end
      if (cyc < 1200)      begin prob = 85;  fpct = 2; end
      else if (cyc < 2200) begin prob = 100; fpct = 0; end
      else if (cyc < 3200) begin prob = 40;  fpct = 3; end
      else                 begin prob = 85;  fpct = 2; end
      drive_random(prob, fpct);

      // Asynchronous reset in the middle of a burst
      if (!rst_done && cyc >= 2600 && m_busy && m_left > 1) begin
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        rst_done    = 1'b1;
        rst_pending = 1'b1;
        s_en = 1'b0;
        @(posedge clk);
        #1 sram_clock();
        continue;
      end

      #1;
      acc       = m_busy && !flush && bus.req[m_owner];
      we        = bus.req_we[m_owner];
      addr      = int'(bus.req_addr[m_owner*ADDR_W +: ADDR_W]);
      wd        = bus.req_wdata[m_owner*DATA_W +: DATA_W];
      exp_ready = (m_busy && !flush) ? (NUM_REQ'(1) << m_owner) : '0;
      exp_rv    = '0;
      exp_rd    = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_rv = NUM_REQ'(1) << pend[0].id;
        exp_rd = pend[0].data;
        void'(pend.pop_front());
      end

      check("req_ready", DATA_W'(bus.req_ready), DATA_W'(exp_ready));
      check("mem_en",    DATA_W'(bus.mem_en),    DATA_W'(acc));
      check("mem_we",    DATA_W'(bus.mem_we),    DATA_W'(acc && we));
      check("mem_addr",  DATA_W'(bus.mem_addr),  acc ? DATA_W'(addr) : '0);
      check("mem_wdata", bus.mem_wdata,          acc ? wd : '0);
      check("rvalid",    DATA_W'(bus.rvalid),    DATA_W'(exp_rv));
      check("rdata",     bus.rdata,              exp_rd);
      check("busy",      DATA_W'(bus.busy),      DATA_W'(m_busy));
      check("owner",     DATA_W'(bus.owner),     DATA_W'(m_owner));

      // Advance the reference model across the coming edge
      if (flush) begin
        pend.delete();
        m_busy = 1'b0;
      end else if (!m_busy) begin
        winner = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (winner < 0 && bus.req[(m_rr + k) % NUM_REQ]) winner = (m_rr + k) % NUM_REQ;
        end
        if (winner >= 0) begin
          m_owner = winner;
          m_left  = int'(bus.req_len[winner*LEN_W +: LEN_W]) + 1;
          m_busy  = 1'b1;
        end
      end else if (acc) begin
        if (we) model_mem[addr] = wd;
        else pend.push_back('{due: cyc + RD_LAT, id: m_owner,
                              data: model_mem.exists(addr) ? model_mem[addr] : default_word(addr)});
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_rr   = (m_owner + 1) % NUM_REQ;
        end
      end

      s_en   = bus.mem_en;
      s_we   = bus.mem_we;
      s_addr = int'(bus.mem_addr);
      s_wd   = bus.mem_wdata;
      @(posedge clk);
      #1 sram_clock();
    end

    if (!rst_done) check("midrst_reached", DATA_W'(rst_done), DATA_W'(1'b1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_buf_arbiter.md
Name: npu_buf_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares the single-port activation buffer among NUM_REQ requesters: 0 = NPU controller, 1 = DMA, 2 = pooling unit.
- Sits between the requesters and the activation SRAM.
- Grants one requester per burst, forwards its beats to the SRAM and routes read data back, tagged to the issuing requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 18, buffer word address width.
- DATA_W, 128, buffer data width.
- LEN_W, 4, burst length field width; a burst is len+1 beats.
- RD_LAT, 1, SRAM read latency in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current burst and of in-flight reads.
- req  in  NUM_REQ  per-requester beat valid.
- req_we  in  NUM_REQ  per-requester write (1) / read (0).
- req_addr  in  NUM_REQ*ADDR_W  per-requester beat address, requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data.
- req_len  in  NUM_REQ*LEN_W  burst beats-1; sampled only at grant.
- req_ready  out  NUM_REQ  beat accepted when req[i] & req_ready[i].
- rvalid  out  NUM_REQ  read data valid for requester i.
- rdata  out  DATA_W  read data, broadcast to all requesters.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read strobe.
- busy  out  1  burst in progress.
- owner  out  3  index of the current grant holder; holds the last owner while idle.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, rr_ptr=0, beat counter 0.
  - Read tag pipeline cleared.
- States:
  - IDLE: if any req is high, the winner is the first requester with req high, searching circularly from rr_ptr. Register owner=winner and cnt=req_len[winner], then go to BURST. No beat is accepted in the arbitration cycle (1-cycle bubble).
  - BURST:
    - req_ready[owner]=1; all other req_ready bits are 0.
    - On accept (req[owner]=1):
      - mem_en=1; mem_we/addr/wdata are combinational pass-through from the owner.
      - If cnt==0: go to IDLE and set rr_ptr=(owner+1) mod NUM_REQ.
      - Else decrement cnt.
    - If req[owner] is low, the arbiter stalls in BURST: mem_en=0, lock held, no timeout.
- mem_* are 0 whenever no beat is accepted.
- Reads:
  - Every accepted read beat pushes {valid, owner} into an RD_LAT-deep shift register.
  - rvalid[tag]=1 and rdata=mem_rdata exactly RD_LAT cycles after the accept.
  - Returns are in order. Reads from a finished burst still return after ownership changes.
- Write beats produce no rvalid.
- busy=1 in BURST. owner updates on the grant edge.
- Fairness: the just-served requester has lowest priority in the next arbitration. Any requester waits at most NUM_REQ-1 bursts.
- Requester changes on req_len after grant are ignored. Requester changes on req_we/addr are honoured per beat.
- flush:
  - Takes priority over all else.
  - Next state is IDLE; cnt cleared; rr_ptr unchanged.
  - The read tag pipeline is zeroed, so no rvalid is issued for outstanding reads.
  - Any beat presented in the flush cycle is not accepted: req_ready=0, mem_en=0.
- Reset mid-burst: immediate return to reset values; pending reads are discarded.
- len=0 gives a single-beat burst: IDLE → BURST → IDLE, 2 cycles minimum per single-beat burst.
- Back-to-back bursts by the same requester still pass through IDLE, during which other requesters win if their req is high.

Test Plan:
- Single read, requester 1, len=0, addr 0x00010, mem_rdata=0xA5..:
  - Grant 1 cycle after req.
  - mem_en one cycle with addr 0x00010.
  - rvalid[1] with rdata 0xA5.. RD_LAT=1 cycle later.
  - rr_ptr=2.
- All three request continuously with len=3, rr_ptr=0:
  - Grant order 0,1,2,0.
  - Each burst exactly 4 mem_en cycles.
  - 1 idle cycle between bursts.
- Owner 2 drops req for 3 cycles mid-burst (len=7):
  - mem_en=0 for those cycles, lock held.
  - Burst completes after 8 total accepted beats.
  - Requesters 0/1 never see req_ready.
- Requester 0 writes 4 beats, then requester 1 reads the same 4 addresses, with RD_LAT=2:
  - Read data matches the written data.
  - rvalid[1] is high only on the 4 cycles 2 after each accept.
- Assert flush one cycle after a read accept by requester 0, with RD_LAT=2:
  - No rvalid[0] for that beat.
  - Next cycle state is IDLE; busy=0.
  - A new arbitration follows with rr_ptr unchanged.
- Assert rst_n=0 during a len=15 burst at beat 5:
  - All outputs 0 immediately.
  - After release, the first grant goes to the lowest-index requesting requester (rr_ptr=0).
